// File: rtl/lap_sched.sv
// lap_sched -- stopwatch control FSM with a lap-time buffer.
//
// Tracks the stopwatch mode (IDLE / RUN / PAUSE / REVIEW) from four active-low
// buttons and captures up to DEPTH lap times from the counting datapath.
//
// Ports
//   i_Clk      system clock, rising edge
//   i_Rst      asynchronous active-high reset
//   i_Start    start/pause button (active-low)
//   i_Stop     stop/clear button (active-low)
//   i_Lap      lap-capture button (active-low)
//   i_Recall   lap-review button (active-low)
//   i_Time     current stopwatch time (TW bits, BCD, stored verbatim)
//   o_Run      count enable, high only in RUN
//   o_Clear    datapath clear, high only in IDLE
//   o_State    IDLE=00 RUN=01 PAUSE=10 REVIEW=11
//   o_LapTime  selected lap time (0 when no laps are stored)
//   o_LapIdx   entry shown in REVIEW
//   o_LapCnt   number of stored laps
//   o_Full     o_LapCnt == DEPTH
module lap_sched #(
  parameter int DEPTH = 8,
  parameter int TW    = 12,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = IW + 1
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Start,
  input  logic          i_Stop,
  input  logic          i_Lap,
  input  logic          i_Recall,
  input  logic [TW-1:0] i_Time,
  output logic          o_Run,
  output logic          o_Clear,
  output logic [1:0]    o_State,
  output logic [TW-1:0] o_LapTime,
  output logic [IW-1:0] o_LapIdx,
  output logic [CW-1:0] o_LapCnt,
  output logic          o_Full
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    REVIEW = 2'b11
  } state_e;

  // Button vector order: [3]=Stop [2]=Start [1]=Lap [0]=Recall (priority high->low)
  logic [3:0]    btn_i;
  logic [3:0]    btn_q;
  logic          arm_q;
  logic [3:0]    press;
  logic          p_stop, p_start, p_lap, p_rec;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] mem_q [DEPTH];

  logic [CW-1:0] last;
  logic          full;
  logic          lap_wr;
  logic [IW-1:0] rd_idx;

  assign btn_i = {i_Stop, i_Start, i_Lap, i_Recall};

  // The copies come out of reset high, so a button already held low at reset
  // release would look like a fresh falling edge. arm_q masks that first cycle.
  assign press = arm_q ? (~btn_i & btn_q) : 4'b0000;

  // Only the highest-priority press in a cycle survives.
  assign p_stop  = press[3];
  assign p_start = press[2] & ~press[3];
  assign p_lap   = press[1] & ~|press[3:2];
  assign p_rec   = press[0] & ~|press[3:1];

  assign last   = cnt_q - CW'(1);
  assign full   = (cnt_q == CW'(DEPTH));
  assign lap_wr = (state_q == RUN) & p_lap & ~full;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      btn_q   <= 4'b1111;
      arm_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      btn_q <= btn_i;
      arm_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (p_start) state_q <= RUN;
        end
        RUN: begin
          if (p_stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else if (p_start) begin
            state_q <= PAUSE;
          end else if (lap_wr) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PAUSE: begin
          if (p_stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else if (p_start) begin
            state_q <= RUN;
          end else if (p_rec && cnt_q != '0) begin
            state_q <= REVIEW;
            idx_q   <= '0;
          end
        end
        REVIEW: begin
          if (p_stop) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else if (p_start) begin
            state_q <= PAUSE;
          end else if (p_rec) begin
            // wrap back to the first lap after the newest one
            if ({1'b0, idx_q} == last) idx_q <= '0;
            else                       idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lap storage needs no reset: entries at or above cnt_q are never selected.
  always_ff @(posedge i_Clk) begin
    if (lap_wr) mem_q[cnt_q[IW-1:0]] <= i_Time;
  end

  assign rd_idx = (state_q == REVIEW) ? idx_q : last[IW-1:0];

  assign o_Run     = (state_q == RUN);
  assign o_Clear   = (state_q == IDLE);
  assign o_State   = state_q;
  assign o_LapIdx  = idx_q;
  assign o_LapCnt  = cnt_q;
  assign o_Full    = full;
  assign o_LapTime = (cnt_q == '0) ? '0 : mem_q[rd_idx];

endmodule
